// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for one arbiter port: request/command toward the
// arbiter, grant and read-return back toward the requester.
interface mem_arbiter_if;
  logic        req;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] data;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, data,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, data,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a 64x32 synchronous-read memory, with a
// built-in clear sequence that walks every word writing zero.
module mem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_arbiter_if.slave       a_if,
  mem_arbiter_if.slave       b_if,
  input  logic               clr_i,
  output logic               busy_o,
  output logic               mem_we_o,
  output logic [5:0]         mem_addr_o,
  output logic [31:0]        mem_data_o,
  input  logic [31:0]        mem_data_i
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       last_b_q, last_b_d;
  logic       a_rv_q, a_rv_d;
  logic       b_rv_q, b_rv_d;
  logic       a_gnt, b_gnt;

  // NOTE: every signal written here is given a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;

    // Reset masks all memory traffic, including an in-flight clear.
    if (!rst_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (clr_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end else begin
            // A wins on conflict unless fair mode says B is owed the slot.
            a_gnt = a_if.req && (!b_if.req || (FAIR == 1'b0) || last_b_q);
            b_gnt = b_if.req && !a_gnt;
            if (a_gnt) begin
              mem_we_o   = a_if.we;
              mem_addr_o = a_if.addr;
              mem_data_o = a_if.data;
              last_b_d   = 1'b0;
            end else if (b_gnt) begin
              mem_we_o   = b_if.we;
              mem_addr_o = b_if.addr;
              mem_data_o = b_if.data;
              last_b_d   = 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          mem_we_o   = 1'b1;
          mem_addr_o = cnt_q;
          cnt_d      = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Memory read data lands one cycle after the grant, so rvalid is a
  // registered copy of "granted read".
  assign a_rv_d = a_gnt && !a_if.we;
  assign b_rv_d = b_gnt && !b_if.we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      a_rv_q   <= a_rv_d;
      b_rv_q   <= b_rv_d;
    end
  end

  assign busy_o      = (state_q == ST_CLEAR);
  assign a_if.gnt    = a_gnt;
  assign b_if.gnt    = b_gnt;
  assign a_if.rvalid = a_rv_q;
  assign b_if.rvalid = b_rv_q;
  assign a_if.rdata  = mem_data_i;
  assign b_if.rdata  = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives a FAIR=1 and a FAIR=0 arbiter with identical stimulus, each with its
// own memory, and checks them against a queue/array-level model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, load_en;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter_if a0 ();
  mem_arbiter_if b0 ();
  mem_arbiter_if a1 ();
  mem_arbiter_if b1 ();

  assign a0.req = a_req;  assign a0.we = a_we;  assign a0.addr = a_addr;  assign a0.data = a_data;
  assign b0.req = b_req;  assign b0.we = b_we;  assign b0.addr = b_addr;  assign b0.data = b_data;
  assign a1.req = a_req;  assign a1.we = a_we;  assign a1.addr = a_addr;  assign a1.data = a_data;
  assign b1.req = b_req;  assign b1.we = b_we;  assign b1.addr = b_addr;  assign b1.data = b_data;

  logic        busy_w      [2];
  logic        mem_we_w    [2];
  logic [5:0]  mem_addr_w  [2];
  logic [31:0] mem_wdata_w [2];
  logic [31:0] mem_rdata_w [2];
  logic        a_gnt_w [2], b_gnt_w [2], a_rv_w [2], b_rv_w [2];
  logic [31:0] a_rd_w [2], b_rd_w [2];

  assign a_gnt_w[0] = a0.gnt;  assign b_gnt_w[0] = b0.gnt;
  assign a_gnt_w[1] = a1.gnt;  assign b_gnt_w[1] = b1.gnt;
  assign a_rv_w[0]  = a0.rvalid;  assign b_rv_w[0] = b0.rvalid;
  assign a_rv_w[1]  = a1.rvalid;  assign b_rv_w[1] = b1.rvalid;
  assign a_rd_w[0]  = a0.rdata;  assign b_rd_w[0] = b0.rdata;
  assign a_rd_w[1]  = a1.rdata;  assign b_rd_w[1] = b1.rdata;

  mem_arbiter #(.FAIR(1'b1)) u_fair (
    .clk_i      (clk),
    .rst_i      (rst),
    .a_if       (a0),
    .b_if       (b0),
    .clr_i      (clr),
    .busy_o     (busy_w[0]),
    .mem_we_o   (mem_we_w[0]),
    .mem_addr_o (mem_addr_w[0]),
    .mem_data_o (mem_wdata_w[0]),
    .mem_data_i (mem_rdata_w[0])
  );

  mem_arbiter #(.FAIR(1'b0)) u_fixed (
    .clk_i      (clk),
    .rst_i      (rst),
    .a_if       (a1),
    .b_if       (b1),
    .clr_i      (clr),
    .busy_o     (busy_w[1]),
    .mem_we_o   (mem_we_w[1]),
    .mem_addr_o (mem_addr_w[1]),
    .mem_data_o (mem_wdata_w[1]),
    .mem_data_i (mem_rdata_w[1])
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Registered-read memories, read-before-write, bulk-loadable.
  logic [31:0] mem [2][64];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load_en) begin
        for (int i = 0; i < 64; i++) mem[k][i] <= init_val(i);
      end else if (mem_we_w[k]) begin
        mem[k][mem_addr_w[k]] <= mem_wdata_w[k];
      end
      mem_rdata_w[k] <= mem[k][mem_addr_w[k]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear progress as "words left", fairness as "who went last".
  int          clr_left [2];
  bit          last_b   [2];
  bit          pa [2], pb [2];
  logic [31:0] pda [2], pdb [2];
  logic [31:0] smem [2][64];
  bit          model_ok = 1'b0;

  always @(negedge clk) begin : model
    bit          fair;
    string       tag;
    logic        e_ag, e_bg, e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wd;
    for (int k = 0; k < 2; k++) begin
      fair   = (k == 0);
      tag    = fair ? "fair" : "fixed";
      e_ag   = 1'b0;
      e_bg   = 1'b0;
      e_we   = 1'b0;
      e_addr = '0;
      e_wd   = '0;
      if (rst) begin
      end else if (clr_left[k] > 0) begin
        e_we   = 1'b1;
        e_addr = 6'(64 - clr_left[k]);
      end else if (!clr) begin
        e_ag = a_req && (!b_req || !fair || last_b[k]);
        e_bg = b_req && !e_ag;
        if (e_ag) begin
          e_we = a_we; e_addr = a_addr; e_wd = a_data;
        end else if (e_bg) begin
          e_we = b_we; e_addr = b_addr; e_wd = b_data;
        end
      end

      check($sformatf("%s a_gnt", tag), 32'(a_gnt_w[k]), 32'(e_ag));
      check($sformatf("%s b_gnt", tag), 32'(b_gnt_w[k]), 32'(e_bg));
      check($sformatf("%s mem_we", tag), 32'(mem_we_w[k]), 32'(e_we));
      if (e_we || e_ag || e_bg)
        check($sformatf("%s mem_addr", tag), 32'(mem_addr_w[k]), 32'(e_addr));
      if (e_we)
        check($sformatf("%s mem_data", tag), mem_wdata_w[k], e_wd);
      if (model_ok) begin
        check($sformatf("%s busy", tag), 32'(busy_w[k]), 32'(clr_left[k] > 0));
        check($sformatf("%s a_rvalid", tag), 32'(a_rv_w[k]), 32'(pa[k]));
        check($sformatf("%s b_rvalid", tag), 32'(b_rv_w[k]), 32'(pb[k]));
        if (pa[k]) check($sformatf("%s a_rdata", tag), a_rd_w[k], pda[k]);
        if (pb[k]) check($sformatf("%s b_rdata", tag), b_rd_w[k], pdb[k]);
      end

      if (rst) begin
        clr_left[k] = 0;
        last_b[k]   = 1'b1;
        pa[k]       = 1'b0;
        pb[k]       = 1'b0;
      end else begin
        pa[k]  = e_ag && !a_we;
        pda[k] = smem[k][a_addr];
        pb[k]  = e_bg && !b_we;
        pdb[k] = smem[k][b_addr];
        if (e_we) smem[k][e_addr] = e_wd;
        if (clr_left[k] > 0) clr_left[k]--;
        else if (clr)        clr_left[k] = 64;
        if (e_ag)      last_b[k] = 1'b0;
        else if (e_bg) last_b[k] = 1'b1;
      end
      if (load_en)
        for (int i = 0; i < 64; i++) smem[k][i] = init_val(i);
    end
    if (rst) model_ok = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load_en = 1'b1; clr = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0;
    repeat (2) step();
    load_en = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("reset busy", 32'(busy_w[0]), 32'd0);
    check("reset a_rvalid", 32'(a_rv_w[0]), 32'd0);
    check("reset b_rvalid", 32'(b_rv_w[0]), 32'd0);

    // Simultaneous reads: A first, then B.
    a_req = 1'b1; a_addr = 6'd3; b_req = 1'b1; b_addr = 6'd5; #1;
    check("both req a_gnt", 32'(a_gnt_w[0]), 32'd1);
    check("both req b_gnt", 32'(b_gnt_w[0]), 32'd0);
    check("both req addr", 32'(mem_addr_w[0]), 32'd3);
    step(); a_req = 1'b0; #1;
    check("second b_gnt", 32'(b_gnt_w[0]), 32'd1);
    check("a_rvalid after read", 32'(a_rv_w[0]), 32'd1);
    check("a_rdata mem[3]", a_rd_w[0], 32'hC0DE_0003);
    step(); b_req = 1'b0; #1;
    check("b_rvalid after read", 32'(b_rv_w[0]), 32'd1);
    check("b_rdata mem[5]", b_rd_w[0], 32'hC0DE_0005);
    check("no stray a_rvalid", 32'(a_rv_w[0]), 32'd0);

    // Six cycles of continuous conflict.
    step(); a_req = 1'b1; b_req = 1'b1; a_addr = 6'd1; b_addr = 6'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr%0d fair a_gnt", i), 32'(a_gnt_w[0]), 32'(i % 2 == 0));
      check($sformatf("rr%0d fair b_gnt", i), 32'(b_gnt_w[0]), 32'(i % 2 == 1));
      check($sformatf("rr%0d fixed a_gnt", i), 32'(a_gnt_w[1]), 32'd1);
      check($sformatf("rr%0d fixed b_gnt", i), 32'(b_gnt_w[1]), 32'd0);
      step();
    end
    a_req = 1'b0; b_req = 1'b0;

    // Write then read-back through the other port.
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_data = 32'hDEAD_BEEF; #1;
    check("write a_gnt", 32'(a_gnt_w[0]), 32'd1);
    check("write mem_we", 32'(mem_we_w[0]), 32'd1);
    check("write mem_data", mem_wdata_w[0], 32'hDEAD_BEEF);
    step(); a_req = 1'b0; a_we = 1'b0; b_req = 1'b1; b_addr = 6'd10; #1;
    check("readback b_gnt", 32'(b_gnt_w[0]), 32'd1);
    check("write gives no a_rvalid", 32'(a_rv_w[0]), 32'd0);
    step(); b_req = 1'b0; #1;
    check("readback b_rdata", b_rd_w[0], 32'hDEAD_BEEF);
    check("readback b_rvalid", 32'(b_rv_w[0]), 32'd1);

    // Read, then clear with A still requesting.
    step(); a_req = 1'b1; a_addr = 6'd7; #1;
    check("pre-clear a_gnt", 32'(a_gnt_w[0]), 32'd1);
    step(); clr = 1'b1; a_addr = 6'd8; #1;
    check("clr cycle a_gnt", 32'(a_gnt_w[0]), 32'd0);
    check("clr cycle mem_we", 32'(mem_we_w[0]), 32'd0);
    check("clr cycle a_rvalid", 32'(a_rv_w[0]), 32'd1);
    check("clr cycle a_rdata", a_rd_w[0], 32'hC0DE_0007);
    step(); clr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      check($sformatf("clear%0d busy", i), 32'(busy_w[0]), 32'd1);
      check($sformatf("clear%0d addr", i), 32'(mem_addr_w[0]), 32'(i));
      check($sformatf("clear%0d a_gnt", i), 32'(a_gnt_w[0]), 32'd0);
      clr = (i == 30);
      step();
    end
    clr = 1'b0; #1;
    check("post-clear busy", 32'(busy_w[0]), 32'd0);
    check("post-clear a_gnt", 32'(a_gnt_w[0]), 32'd1);
    step(); a_req = 1'b0; b_req = 1'b1; b_addr = 6'd63; #1;
    check("cleared a_rdata", a_rd_w[0], 32'd0);
    check("cleared a_rvalid", 32'(a_rv_w[0]), 32'd1);
    step(); b_req = 1'b0; #1;
    check("cleared b_rdata", b_rd_w[0], 32'd0);

    // Reset in the middle of a clear.
    step(); load_en = 1'b1;
    step(); load_en = 1'b0; clr = 1'b1;
    step(); clr = 1'b0;
    repeat (20) step();
    rst = 1'b1; a_req = 1'b1; a_addr = 6'd0; #1;
    check("rst mid-clear mem_we", 32'(mem_we_w[0]), 32'd0);
    check("rst mid-clear a_gnt", 32'(a_gnt_w[0]), 32'd0);
    step(); rst = 1'b0; a_addr = 6'd19; #1;
    check("after abort busy", 32'(busy_w[0]), 32'd0);
    step(); a_addr = 6'd40; #1;
    check("abort addr19", a_rd_w[0], 32'd0);
    step(); a_addr = 6'd20; #1;
    check("abort addr40", a_rd_w[0], 32'hC0DE_0028);
    step(); a_req = 1'b0; #1;
    check("abort addr20", a_rd_w[0], 32'hC0DE_0014);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin between ports, 0 = fixed priority to port A.
REQ-002 clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 a_req_i / b_req_i  input  1  per-port access request, held until granted.
REQ-005 a_we_i / b_we_i  input  1  per-port write enable (1 write, 0 read), qualified by req.
REQ-006 a_addr_i / b_addr_i  input  6  per-port word address (0..63).
REQ-007 a_data_i / b_data_i  input  32  per-port write data.
REQ-008 a_gnt_o / b_gnt_o  output  1  grant; access issued to memory this cycle.
REQ-009 a_rvalid_o / b_rvalid_o  output  1  read data valid for that port.
REQ-010 a_rdata_o / b_rdata_o  output  32  read data, meaningful only while the matching rvalid is high.
REQ-011 clr_i  input  1  pulse; starts clear sequence writing zero to all 64 words.
REQ-012 busy_o  output  1  high while the clear sequence runs.
REQ-013 mem_we_o  output  1  memory write enable.
REQ-014 mem_addr_o  output  6  memory address.
REQ-015 mem_data_o  output  32  memory write data.
REQ-016 mem_data_i  input  32  memory registered read data (1-cycle latency, read-before-write).

Function
REQ-017 The block SHALL implement two states: IDLE (arbitrating) and CLEAR.
REQ-018 In IDLE with clr_i low, at most one grant SHALL be asserted per cycle; gnt is combinational from req and arbitration state.
REQ-019 Granted port's we/addr/data SHALL drive mem_we_o/mem_addr_o/mem_data_o combinationally in the grant cycle; with no grant mem_we_o = 0.
REQ-020 Single requester SHALL be granted in the same cycle it requests.
REQ-021 FAIR=1 conflict: grant the port not granted most recently; last-grant pointer updates on every grant.
REQ-022 FAIR=0 conflict: port A always wins; B waits.
REQ-023 Granted read SHALL raise that port's rvalid exactly one cycle after grant, for one cycle, with rdata = mem_data_i.
REQ-024 Granted write SHALL produce no rvalid.
REQ-025 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle).
REQ-026 clr_i high in IDLE SHALL take priority over requests: no grant that cycle; state -> CLEAR, counter = 0.
REQ-027 In CLEAR: mem_we_o = 1, mem_data_o = 0, mem_addr_o = counter; counter increments each cycle; no grants; busy_o = 1.
REQ-028 After counter = 63 is written, state SHALL return to IDLE next cycle (64 CLEAR cycles total); counter wraps to 0.
REQ-029 clr_i during CLEAR SHALL be ignored (no restart).
REQ-030 rvalid for a read granted in the cycle before clr_i SHALL still be delivered in the first CLEAR cycle.

Reset
REQ-031 rst_i high SHALL on next edge force: state IDLE, counter 0, busy_o 0, both rvalid 0, last-grant pointer = B (so A wins first FAIR conflict).
REQ-032 Reset mid-CLEAR SHALL abort the sequence; words not yet written keep their contents.
REQ-033 While rst_i is high, no grants SHALL be asserted and mem_we_o = 0.

Verification
REQ-034 After reset, A and B both read (A addr 3, B addr 5) simultaneously, FAIR=1 -> A granted cycle 0, B cycle 1; a_rvalid at cycle 1 with mem[3], b_rvalid at cycle 2 with mem[5].
REQ-035 FAIR=1, both hold requests continuously for 6 cycles -> grants alternate A,B,A,B,A,B; FAIR=0 same stimulus -> A six times, B none.
REQ-036 A writes 0xDEADBEEF to addr 10, then B reads addr 10 next cycle -> b_rvalid one cycle later with 0xDEADBEEF; no a_rvalid.
REQ-037 clr_i pulse with A requesting -> busy_o high 64 cycles, mem_addr_o 0..63 with data 0, no a_gnt until busy_o falls; then read any address -> 0.
REQ-038 rst_i asserted at clear counter 20 -> busy_o 0 next cycle; addr 19 reads 0, addr 40 reads its preloaded value.
